// File: rtl/qslave_seq_pkg.sv
// rtl/qslave_seq_pkg.sv - shared types and constants for the QBUS slave-cycle sequencer
//
// Holds the sequencer state encoding, the byte-enable codes driven on
// wr_bytes, the default settle/timeout values and the index/counter widths.
package qslave_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_TX    = 3'd1,
        ST_RD_RPLY  = 3'd2,
        ST_WR_RPLY  = 3'd3,
        ST_VEC_TX   = 3'd4,
        ST_VEC_RPLY = 3'd5,
        ST_WAIT_END = 3'd6
    } state_e;

    // Byte enables {hi, lo}
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    localparam int SETTLE_DEFAULT  = 2;
    localparam int TIMEOUT_DEFAULT = 4095;

    // Device index is wide enough for the maximum of 8 channels
    localparam int IDX_W = 3;
    localparam int CNT_W = 12;

    // DATOB (WTBT asserted) writes a single byte chosen by address bit 0
    function automatic logic [1:0] byte_enables(input logic wtbt, input logic a0);
        if (!wtbt) begin
            return BE_WORD;
        end
        return a0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/qslave_seq_qsync.sv
// rtl/qslave_seq_qsync.sv - N-stage synchroniser with rising-edge pulse
//
// Ports:
//   clk   in   sampling clock
//   rst_n in   asynchronous active-low reset
//   d     in   raw asynchronous input
//   q     out  synchronised level (STAGES clocks of latency)
//   rise  out  high for one clock when q goes 0 -> 1
module qslave_seq_qsync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sh_q;
    logic [STAGES-1:0] sh_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sh_d   = {sh_q[STAGES-2:0], d};
        prev_d = sh_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            prev_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sh_q[STAGES-1];
    assign rise = sh_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/qslave_seq.sv
// rtl/qslave_seq.sv - QBUS slave-cycle sequencer (DATI/DATO/DATOB/vector) for NDEV devices
//
// Ports:
//   clk20, reset_n              clock and asynchronous active-low reset
//   RSYNC, RDIN, RDOUT, RINIT   raw bus strobes (synchronised here)
//   RWTBT, addr0                byte-write indicator and address bit 0
//   dev_match, dev_vector       per-device address match / vector request
//   dev_rdata                   per-device read data, device i at [16i+15:16i]
//   tdl                         registered transmit data
//   DALtx, DALbe, DALst, TRPLY  transceiver controls and reply
//   rd_strobe, wr_strobe        one-clock per-device access pulses
//   wr_bytes                    byte enables {hi, lo}, valid with wr_strobe
//   busy, err_timeout           sequencer active / reply timeout pulse
module qslave_seq
    import qslave_seq_pkg::*;
#(
    parameter int NDEV        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = SETTLE_DEFAULT,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic              clk20,
    input  logic              reset_n,
    input  logic              RSYNC,
    input  logic              RDIN,
    input  logic              RDOUT,
    input  logic              RINIT,
    input  logic              RWTBT,
    input  logic              addr0,
    input  logic [NDEV-1:0]   dev_match,
    input  logic [NDEV-1:0]   dev_vector,
    input  logic [16*NDEV-1:0] dev_rdata,
    output logic [15:0]       tdl,
    output logic              DALtx,
    output logic              DALbe,
    output logic              DALst,
    output logic              TRPLY,
    output logic [NDEV-1:0]   rd_strobe,
    output logic [NDEV-1:0]   wr_strobe,
    output logic [1:0]        wr_bytes,
    output logic              busy,
    output logic              err_timeout
);

    // Strobe order in the vectors below: {RINIT, RDOUT, RDIN, RSYNC}
    logic [3:0] raw_strb;
    logic [3:0] s_strb;
    logic [3:0] r_strb;
    logic       unused_rise;

    assign raw_strb = {RINIT, RDOUT, RDIN, RSYNC};

    for (genvar g = 0; g < 4; g++) begin : g_sync
        qslave_seq_qsync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk20),
            .rst_n(reset_n),
            .d    (raw_strb[g]),
            .q    (s_strb[g]),
            .rise (r_strb[g])
        );
    end

    logic s_rsync, s_rdin, s_rdout, s_rinit, rdout_rise;
    assign s_rsync    = s_strb[0];
    assign s_rdin     = s_strb[1];
    assign s_rdout    = s_strb[2];
    assign s_rinit    = s_strb[3];
    assign rdout_rise = r_strb[2];
    // Only the DOUT edge starts a cycle; the other edge pulses are spare
    assign unused_rise = ^{r_strb[3], r_strb[1:0]};

    function automatic logic [IDX_W-1:0] lowest(input logic [NDEV-1:0] v);
        lowest = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    function automatic logic [NDEV-1:0] onehot(input logic [IDX_W-1:0] idx);
        for (int i = 0; i < NDEV; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    endfunction

    function automatic logic [15:0] pick(input logic [IDX_W-1:0] idx,
                                         input logic [16*NDEV-1:0] data);
        pick = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (idx == IDX_W'(i)) pick = data[16*i +: 16];
        end
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic              vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       tdl_q, tdl_d;
    logic              daltx_q, daltx_d;
    logic              dalbe_q, dalbe_d;
    logic              dalst_q, dalst_d;
    logic              trply_q, trply_d;
    logic [NDEV-1:0]   rd_strobe_q, rd_strobe_d;
    logic [NDEV-1:0]   wr_strobe_q, wr_strobe_d;
    logic [1:0]        wr_bytes_q, wr_bytes_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic any_match, any_vec, rd_reply_next;

    assign any_match = |dev_match;
    assign any_vec   = |dev_vector;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        rd_strobe_d = '0;
        wr_strobe_d = '0;
        wr_bytes_d  = 2'b00;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // RSYNC decides between a register cycle and a vector read
                if (s_rsync && s_rdin && any_match) begin
                    sel_d   = lowest(dev_match);
                    vec_d   = 1'b0;
                    state_d = (SETTLE == 0) ? ST_RD_RPLY : ST_RD_TX;
                end else if (!s_rsync && s_rdin && any_vec) begin
                    sel_d   = lowest(dev_vector);
                    vec_d   = 1'b1;
                    state_d = (SETTLE == 0) ? ST_VEC_RPLY : ST_VEC_TX;
                end else if (s_rsync && rdout_rise && any_match) begin
                    sel_d   = lowest(dev_match);
                    vec_d   = 1'b0;
                    state_d = ST_WR_RPLY;
                end
            end
            ST_RD_TX, ST_VEC_TX: begin
                // Hold DALtx alone until the cable has settled
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_RD_TX) ? ST_RD_RPLY : ST_VEC_RPLY;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_RD_RPLY, ST_VEC_RPLY: begin
                if (!s_rdin) begin
                    state_d = ST_WAIT_END;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_END;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_WR_RPLY: begin
                if (!s_rdout) begin
                    state_d = ST_WAIT_END;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_END;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_WAIT_END: begin
                // A register cycle must also see SYNC released, so the DOUT
                // half of a read-modify-write is not replied to a second time
                if (!s_rdin && !s_rdout && (vec_q || !s_rsync)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_reply_next = (state_d == ST_RD_RPLY) || (state_d == ST_VEC_RPLY);

        if (rd_reply_next && (state_q != state_d)) begin
            rd_strobe_d = onehot(sel_d);
        end
        if ((state_d == ST_WR_RPLY) && (state_q != ST_WR_RPLY)) begin
            wr_strobe_d = onehot(sel_d);
            wr_bytes_d  = byte_enables(RWTBT, addr0);
        end

        daltx_d = rd_reply_next || (state_d == ST_RD_TX) || (state_d == ST_VEC_TX);
        dalbe_d = rd_reply_next;
        dalst_d = rd_reply_next;
        trply_d = rd_reply_next || (state_d == ST_WR_RPLY);
        busy_d  = (state_d != ST_IDLE);

        // Data follows the selected device while settling, then freezes
        if ((state_d == ST_RD_TX) || (state_d == ST_VEC_TX)) begin
            tdl_d = pick(sel_d, dev_rdata);
        end else if (rd_reply_next) begin
            tdl_d = tdl_q;
        end else begin
            tdl_d = '0;
        end

        if (s_rinit) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            err_d       = 1'b0;
            rd_strobe_d = '0;
            wr_strobe_d = '0;
            wr_bytes_d  = 2'b00;
            daltx_d     = 1'b0;
            dalbe_d     = 1'b0;
            dalst_d     = 1'b0;
            trply_d     = 1'b0;
            busy_d      = 1'b0;
            tdl_d       = '0;
        end
    end

    always_ff @(posedge clk20 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            vec_q       <= 1'b0;
            cnt_q       <= '0;
            tdl_q       <= '0;
            daltx_q     <= 1'b0;
            dalbe_q     <= 1'b0;
            dalst_q     <= 1'b0;
            trply_q     <= 1'b0;
            rd_strobe_q <= '0;
            wr_strobe_q <= '0;
            wr_bytes_q  <= 2'b00;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            tdl_q       <= tdl_d;
            daltx_q     <= daltx_d;
            dalbe_q     <= dalbe_d;
            dalst_q     <= dalst_d;
            trply_q     <= trply_d;
            rd_strobe_q <= rd_strobe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_bytes_q  <= wr_bytes_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign tdl         = tdl_q;
    assign DALtx       = daltx_q;
    assign DALbe       = dalbe_q;
    assign DALst       = dalst_q;
    assign TRPLY       = trply_q;
    assign rd_strobe   = rd_strobe_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_bytes    = wr_bytes_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_qslave_seq.sv
// tb/tb_qslave_seq.sv - scoreboard bench for qslave_seq
module tb_qslave_seq;

    localparam int NDEV    = 4;
    localparam int SYNC    = 2;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        RSYNC = 0, RDIN = 0, RDOUT = 0, RINIT = 0, RWTBT = 0, addr0 = 0;
    logic [3:0]  dev_match = '0, dev_vector = '0;
    logic [15:0] rdata_arr [4];
    logic [63:0] dev_rdata;
    logic [15:0] tdl;
    logic        DALtx, DALbe, DALst, TRPLY, busy, err_timeout;
    logic [3:0]  rd_strobe, wr_strobe;
    logic [1:0]  wr_bytes;

    assign dev_rdata = {rdata_arr[3], rdata_arr[2], rdata_arr[1], rdata_arr[0]};

    qslave_seq #(.NDEV(NDEV), .SYNC_STAGES(SYNC), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk20(clk), .reset_n(reset_n),
        .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RINIT(RINIT),
        .RWTBT(RWTBT), .addr0(addr0),
        .dev_match(dev_match), .dev_vector(dev_vector), .dev_rdata(dev_rdata),
        .tdl(tdl), .DALtx(DALtx), .DALbe(DALbe), .DALst(DALst), .TRPLY(TRPLY),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .wr_bytes(wr_bytes),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #25 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;    // 0 read, 1 write, 2 timeout
        logic [3:0]  strobe;
        logic [15:0] data;
        logic [1:0]  bytes;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference rules: lowest requesting device wins; DATOB picks a byte by addr0
    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [1:0] exp_bytes(input logic wtbt, input logic a0);
        if (!wtbt) return 2'b11;
        return a0 ? 2'b10 : 2'b01;
    endfunction

    // Monitor: every strobe or timeout pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rd_strobe != 4'b0 || wr_strobe != 4'b0 || err_timeout) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: rd=%b wr=%b err=%b with nothing expected",
                         rd_strobe, wr_strobe, err_timeout);
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    0: begin
                        check("rd_strobe", 32'(rd_strobe), 32'(mon_e.strobe));
                        check("wr_strobe_on_read", 32'(wr_strobe), 32'h0);
                        check("tdl", 32'(tdl), 32'(mon_e.data));
                        check("read_controls", 32'({DALtx, DALbe, DALst, TRPLY}), 32'hF);
                    end
                    1: begin
                        check("wr_strobe", 32'(wr_strobe), 32'(mon_e.strobe));
                        check("rd_strobe_on_write", 32'(rd_strobe), 32'h0);
                        check("wr_bytes", 32'(wr_bytes), 32'(mon_e.bytes));
                        check("write_controls", 32'({DALtx, TRPLY}), 32'h1);
                    end
                    default: begin
                        check("err_timeout", 32'(err_timeout), 32'h1);
                        check("strobes_on_timeout", 32'({rd_strobe, wr_strobe}), 32'h0);
                        check("trply_after_timeout", 32'(TRPLY), 32'h0);
                    end
                endcase
            end
        end
    end

    // Edges counted from the drive point until: 0 DALtx high, 1 TRPLY high, 2 TRPLY low
    task automatic measure(input int which, output int edges);
        int n;
        n = 0;
        edges = -1;
        while (edges < 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if ((which == 0 && DALtx) || (which == 1 && TRPLY) || (which == 2 && !TRPLY))
                edges = n;
        end
    endtask

    task automatic finish_cycle();
        int n;
        RSYNC = 0; dev_match = '0; dev_vector = '0; RWTBT = 0; addr0 = 0;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("back_to_idle", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit vec, input logic [3:0] mask, input logic [3:0] noise,
                           input int hold, input bit expect_timeout);
        int idx, e1, e2, e3, cnt;
        exp_t e;
        idx = lowest(mask);
        if (vec) begin
            RSYNC = 0; dev_vector = mask; dev_match = noise;
        end else begin
            RSYNC = 1; dev_match = mask; dev_vector = noise;
        end
        repeat (3) @(posedge clk);
        #1;
        e.kind = 0; e.strobe = 4'(1 << idx); e.data = rdata_arr[idx]; e.bytes = 2'b00;
        sb.push_back(e);
        if (expect_timeout) begin
            e.kind = 2; e.strobe = '0; e.data = '0;
            sb.push_back(e);
        end
        RDIN = 1;
        measure(0, e1);
        check("daltx_edge", e1, SYNC + 1);
        measure(1, e2);
        check("trply_edge", e1 + e2, SYNC + 1 + SETTLE);
        if (expect_timeout) begin
            cnt = 1;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (TRPLY) cnt++;
            end
            check("timeout_reply_clocks", cnt, TIMEOUT);
            RDIN = 0;
        end else begin
            repeat (hold) @(posedge clk);
            #1;
            RDIN = 0;
            measure(2, e3);
            check("read_release", e3, SYNC + 1);
        end
        finish_cycle();
    endtask

    task automatic do_write(input logic [3:0] mask, input logic [3:0] noise,
                            input logic wtbt, input logic a0, input int hold);
        int e1, e3;
        exp_t e;
        RSYNC = 1; dev_match = mask; dev_vector = noise;
        repeat (3) @(posedge clk);
        #1;
        e.kind = 1; e.strobe = 4'(1 << lowest(mask)); e.data = '0; e.bytes = exp_bytes(wtbt, a0);
        sb.push_back(e);
        RWTBT = wtbt; addr0 = a0; RDOUT = 1;
        measure(1, e1);
        check("write_trply_edge", e1, SYNC + 1);
        repeat (hold) @(posedge clk);
        #1;
        RDOUT = 0;
        measure(2, e3);
        check("write_release", e3, SYNC + 1);
        finish_cycle();
    endtask

    initial begin
        int e1, e2, kind;
        exp_t e;
        for (int i = 0; i < 4; i++) rdata_arr[i] = 16'(32'h1111 * (i + 1));
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({DALtx, DALbe, DALst, TRPLY, busy, err_timeout}), 32'h0);
        check("reset_strobes", 32'({rd_strobe, wr_strobe, wr_bytes}), 32'h0);
        check("reset_tdl", 32'(tdl), 32'h0);
        reset_n = 1;
        repeat (3) @(posedge clk);
        #1;

        rdata_arr[2] = 16'o123456;
        do_read(0, 4'b0100, 4'b0000, 2, 0);
        do_write(4'b0001, 4'b0000, 1'b1, 1'b1, 1);
        do_write(4'b0001, 4'b0000, 1'b0, 1'b1, 1);
        rdata_arr[1] = 16'hA1A1; rdata_arr[3] = 16'h3C3C;
        do_read(0, 4'b1010, 4'b0000, 1, 0);
        rdata_arr[0] = 16'o000220;
        do_read(1, 4'b0001, 4'b0110, 1, 0);

        // Init aborts a read in progress
        RSYNC = 1; dev_match = 4'b0010; rdata_arr[1] = 16'h5A5A;
        repeat (3) @(posedge clk);
        #1;
        e.kind = 0; e.strobe = 4'b0010; e.data = 16'h5A5A; e.bytes = 2'b00;
        sb.push_back(e);
        RDIN = 1;
        measure(1, e1);
        check("rinit_pre_trply_edge", e1, SYNC + 1 + SETTLE);
        RINIT = 1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        check("rinit_controls", 32'({DALtx, DALbe, DALst, TRPLY, busy}), 32'h0);
        check("rinit_tdl", 32'(tdl), 32'h0);
        RDIN = 0; RSYNC = 0; dev_match = '0;
        repeat (2) @(posedge clk);
        #1;
        RINIT = 0;
        repeat (3) @(posedge clk);
        #1;
        finish_cycle();

        do_read(0, 4'b0001, 4'b0000, 0, 1);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) rdata_arr[i] = 16'($urandom);
            kind = $urandom_range(0, 2);
            case (kind)
                0: do_read(0, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                           $urandom_range(0, 4), 0);
                1: do_read(1, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                           $urandom_range(0, 4), 0);
                default: do_write(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  $urandom_range(0, 4));
            endcase
        end

        // Asynchronous reset in the middle of a write reply
        RSYNC = 1; dev_match = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        e.kind = 1; e.strobe = 4'b1000; e.data = '0; e.bytes = 2'b11;
        sb.push_back(e);
        RDOUT = 1;
        measure(1, e2);
        check("pre_reset_trply_edge", e2, SYNC + 1);
        @(posedge clk);
        #10;
        reset_n = 0;
        #1;
        check("async_reset_trply", 32'({TRPLY, busy}), 32'h0);
        RDOUT = 0; RSYNC = 0; dev_match = '0;
        @(posedge clk);
        #1;
        reset_n = 1;
        repeat (4) @(posedge clk);
        #1;

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qslave_seq.md
# qslave_seq

Parametrised QBUS slave-cycle sequencer for the QSIC: it synchronises the raw bus strobes, arbitrates among NDEV register devices and sequences the Am2908 transceiver controls. It handles DATI, DATO, DATOB and interrupt-vector reads, and issues per-device read/write strobes with byte enables. It sits between the per-device address decoders (switch register, RKV11, future controllers) and the board-level DALtx/DALbe/DALst/TRPLY pins. It replaces the fixed single-path reply logic in the board top level.

## Interface
- NDEV, 4: number of device channels, 1..8
- SYNC_STAGES, 2: synchroniser depth on RSYNC/RDIN/RDOUT/RINIT, ≥2
- SETTLE, 2: clocks between DALtx assertion and TRPLY/DALbe/DALst (ribbon-cable settle), 0..15
- TIMEOUT, 4095: max clocks TRPLY is held awaiting master release, 12-bit
- clk20  in  1  20 MHz QBUS clock
- reset_n  in  1  asynchronous, active-low reset
- RSYNC, RDIN, RDOUT, RINIT  in  1 each  raw asynchronous bus receivers
- RWTBT  in  1  raw WTBT during data phase (DATOB indicator)
- addr0  in  1  latched address bit 0
- dev_match  in  NDEV  per-device address match (from RSYNC-latched address)
- dev_vector  in  NDEV  per-device vector request (from qint)
- dev_rdata  in  16*NDEV  flattened read data, device i at [16i+15:16i]
- tdl  out  16  registered transmit data to TDAL mux
- DALtx, DALbe, DALst, TRPLY  out  1 each  transceiver controls / reply
- rd_strobe, wr_strobe  out  NDEV each  one-clock pulse to the selected device
- wr_bytes  out  2  byte enables {hi, lo}, valid with wr_strobe
- busy  out  1  FSM not IDLE
- err_timeout  out  1  one-clock pulse on reply timeout

## Operation
- Reset (reset_n low) or synchronised RINIT: all outputs 0, tdl 0, FSM IDLE. RINIT takes effect one clock after sync, aborting any cycle mid-reply.
- Selection: lowest-index asserted dev_match (RSYNC cycles) or dev_vector (sRSYNC low). Index is frozen at IDLE exit.
- States: IDLE, RD_TX, RD_RPLY, WR_RPLY, VEC_TX, VEC_RPLY, WAIT_END.
- IDLE→RD_TX: sRSYNC & sRDIN & any dev_match. IDLE→VEC_TX: ~sRSYNC & sRDIN & any dev_vector. IDLE→WR_RPLY: rising sRDOUT & sRSYNC & any dev_match.
- RD_TX/VEC_TX: DALtx=1, tdl tracks selected dev_rdata; after SETTLE clocks go to *_RPLY.
- RD_RPLY/VEC_RPLY: DALtx=DALbe=DALst=TRPLY=1; tdl frozen; rd_strobe pulses on entry; exit to WAIT_END when sRDIN drops.
- WR_RPLY: TRPLY=1; wr_strobe pulses on entry with wr_bytes = RWTBT ? (addr0 ? 2'b10 : 2'b01) : 2'b11 (sampled that clock); exit to WAIT_END when sRDOUT drops.
- WAIT_END: all controls 0; return to IDLE when sRDIN=sRDOUT=0 (and sRSYNC=0 for register cycles). This prevents double-reply on a DATIO read-modify-write.
- Timeout: a 12-bit counter runs in *_RPLY. On reaching TIMEOUT, pulse err_timeout and go to WAIT_END.
- A match lost mid-cycle is ignored (index is frozen). Simultaneous match and vector at IDLE: RSYNC decides.

## Timing
- Raw edge before clk edge 0 → synced at edge SYNC_STAGES.
- Read: DALtx rises at edge SYNC_STAGES+1. TRPLY/DALbe/DALst rise at edge SYNC_STAGES+1+SETTLE (defaults: edges 3 and 5).
- Write: TRPLY and wr_strobe at edge SYNC_STAGES+1.
- Release: TRPLY drops one clock after the synced strobe falls, i.e. SYNC_STAGES+1 clocks after the raw strobe falls.
- All outputs registered; no combinational input→output paths.

## Structure
- qsic.vh gains state encodings, byte-enable constants (BE_WORD, BE_LO, BE_HI) and the default SETTLE/TIMEOUT values.
- Sub-module qsync (parametrised N-stage synchroniser with rise-pulse output), instanced for each of the four strobes.
- Priority encoder and data mux stay inline.

## Test plan
- DATI to device 2 (dev_rdata=16'o123456), defaults: DALtx at edge 3, TRPLY/DALbe/DALst at edge 5, tdl=16'o123456, one rd_strobe[2]; TRPLY drops 3 clocks after RDIN falls.
- DATOB with RWTBT=1, addr0=1 to device 0: wr_strobe[0] one clock at edge 3, wr_bytes=2'b10; with RWTBT=0 → 2'b11.
- Devices 1 and 3 both match: only device 1 is strobed and its data driven.
- Vector read (RSYNC low, dev_vector[0], rdata=16'o000220): VEC sequence gives tdl=16'o000220 and TRPLY at edge 5.
- RINIT pulse during RD_RPLY: all outputs 0 within SYNC_STAGES+1 clocks and FSM in IDLE. reset_n low mid-write clears TRPLY immediately (asynchronous).
- TIMEOUT=20, RDIN held high: err_timeout pulses once after 20 reply clocks, TRPLY drops, no re-reply until RDIN falls.
